// File: rtl/gcm_pkg.sv
// Shared widths and state encoding for the GCM input sequencer.
package gcm_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 128;
  localparam int IV_W  = 96;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AAD   = 2'd1,
    PT    = 2'd2,
    EMPTY = 2'd3
  } seq_state_t;

endpackage

// File: rtl/gcm_input_sequencer.sv
// Producer side of the AES-GCM pipeline input. Frames one descriptor plus its
// AAD/PT data stream into one-block-per-cycle pipeline beats; upstream gaps
// become bubbles because the pipeline itself cannot stall.
//
// state | meaning
// IDLE  | waiting for a descriptor; o_desc_ready high (except while o_last shows)
// AAD   | accepting AAD blocks; counter holds remaining AAD blocks
// PT    | accepting PT blocks; counter holds remaining PT blocks
// EMPTY | zero-length instance; emits a single all-zero AAD beat
module gcm_input_sequencer
  import gcm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_desc_valid,
  output logic               o_desc_ready,
  input  logic [0:KEY_W-1]   i_desc_key,
  input  logic [0:IV_W-1]    i_desc_iv,
  input  logic [CNT_W-1:0]   i_desc_aad_blocks,
  input  logic [CNT_W-1:0]   i_desc_pt_blocks,
  input  logic [0:BLK_W-1]   i_desc_instance_size,
  input  logic               i_data_valid,
  output logic               o_data_ready,
  input  logic [0:BLK_W-1]   i_data,
  output logic               o_valid,
  output logic [0:KEY_W-1]   o_cipher_key,
  output logic [0:BLK_W-1]   o_plain_text,
  output logic [0:BLK_W-1]   o_aad,
  output logic [0:IV_W-1]    o_iv,
  output logic [0:BLK_W-1]   o_instance_size,
  output logic               o_new_instance,
  output logic               o_pt_instance,
  output logic               o_last
);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  pt_blocks_q;
  logic [0:KEY_W-1]  key_q;
  logic [0:IV_W-1]   iv_q;
  logic [0:BLK_W-1]  size_q;
  logic              first_q;

  logic desc_fire;
  logic data_fire;
  logic cnt_is_one;
  logic emit;
  logic beat_last;

  assign desc_fire  = i_desc_valid && o_desc_ready;
  assign data_fire  = i_data_valid && o_data_ready;
  assign cnt_is_one = (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode: move on when the final block of a phase is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (desc_fire) begin
          if (i_desc_aad_blocks != '0)     state_d = AAD;
          else if (i_desc_pt_blocks != '0) state_d = PT;
          else                             state_d = EMPTY;
        end
      end
      AAD:     if (data_fire && cnt_is_one) state_d = (pt_blocks_q != '0) ? PT : IDLE;
      PT:      if (data_fire && cnt_is_one) state_d = IDLE;
      EMPTY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and beat-framing strobes; descriptor accept is held off while the
  // previous instance's last beat is still on the outputs, guaranteeing a gap
  always_comb begin
    o_desc_ready = !rst && (state_q == IDLE) && !o_last;
    o_data_ready = !rst && ((state_q == AAD) || (state_q == PT));
    emit         = data_fire || (state_q == EMPTY);
    beat_last    = (state_q == EMPTY)
                || ((state_q == PT)  && cnt_is_one)
                || ((state_q == AAD) && cnt_is_one && (pt_blocks_q == '0));
  end

  // Block down-counter: loaded on phase entry, decremented per accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (desc_fire)
                cnt_q <= (i_desc_aad_blocks != '0) ? i_desc_aad_blocks : i_desc_pt_blocks;
        AAD:  if (data_fire)
                cnt_q <= cnt_is_one ? pt_blocks_q : (cnt_q - CNT_W'(1));
        PT:   if (data_fire)
                cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Descriptor hold registers; first_q marks the next emitted beat as new_instance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      iv_q        <= '0;
      size_q      <= '0;
      pt_blocks_q <= '0;
      first_q     <= 1'b0;
    end else if (desc_fire) begin
      key_q       <= i_desc_key;
      iv_q        <= i_desc_iv;
      size_q      <= i_desc_instance_size;
      pt_blocks_q <= i_desc_pt_blocks;
      first_q     <= 1'b1;
    end else if (emit) begin
      first_q     <= 1'b0;
    end
  end

  // Registered pipeline beat; a cycle without an accepted block is a zero bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid        <= 1'b0;
      o_new_instance <= 1'b0;
      o_pt_instance  <= 1'b0;
      o_last         <= 1'b0;
      o_plain_text   <= '0;
      o_aad          <= '0;
    end else begin
      o_valid        <= emit;
      o_new_instance <= emit && first_q;
      o_pt_instance  <= data_fire && (state_q == PT);
      o_last         <= emit && beat_last;
      o_plain_text   <= (data_fire && (state_q == PT))  ? i_data : '0;
      o_aad          <= (data_fire && (state_q == AAD)) ? i_data : '0;
    end
  end

  assign o_cipher_key    = key_q;
  assign o_iv            = iv_q;
  assign o_instance_size = size_q;

endmodule

// File: tb/tb_gcm_input_sequencer.sv
// Directed bench for gcm_input_sequencer: framing, bubbles, empty instance,
// descriptor back-pressure and mid-instance reset.
module tb_gcm_input_sequencer;

  localparam int CNT_W = 16;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K3 = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [127:0] K4 = 128'h303132333435363738393a3b3c3d3e3f;
  localparam logic [127:0] K5 = 128'h404142434445464748494a4b4c4d4e4f;
  localparam logic [127:0] K6 = 128'h505152535455565758595a5b5c5d5e5f;
  localparam logic [127:0] K7 = 128'h606162636465666768696a6b6c6d6e6f;
  localparam logic [95:0]  IV1 = 96'hcafebabefacedbaddecaf888;
  localparam logic [95:0]  IV4 = 96'h111111112222222233333333;
  localparam logic [95:0]  IV5 = 96'h444444445555555566666666;
  localparam logic [127:0] S1 = 128'h00000000000000800000000000000100;
  localparam logic [127:0] S4 = 128'h00000000000000000000000000000100;
  localparam logic [127:0] S5 = 128'h00000000000000800000000000000000;
  localparam logic [127:0] A0 = 128'ha0a0a0a0a0a0a0a0a0a0a0a0a0a0a0a0;
  localparam logic [127:0] P0 = 128'hb0b0b0b0b0b0b0b0b0b0b0b0b0b0b0b0;
  localparam logic [127:0] P1 = 128'hb1b1b1b1b1b1b1b1b1b1b1b1b1b1b1b1;
  localparam logic [127:0] P2 = 128'hb2b2b2b2b2b2b2b2b2b2b2b2b2b2b2b2;
  localparam logic [127:0] JUNK = 128'hdeaddeaddeaddeaddeaddeaddeaddead;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_desc_valid = 1'b0;
  logic              o_desc_ready;
  logic [0:127]      i_desc_key = '0;
  logic [0:95]       i_desc_iv = '0;
  logic [CNT_W-1:0]  i_desc_aad_blocks = '0;
  logic [CNT_W-1:0]  i_desc_pt_blocks = '0;
  logic [0:127]      i_desc_instance_size = '0;
  logic              i_data_valid = 1'b0;
  logic              o_data_ready;
  logic [0:127]      i_data = '0;
  logic              o_valid;
  logic [0:127]      o_cipher_key;
  logic [0:127]      o_plain_text;
  logic [0:127]      o_aad;
  logic [0:95]       o_iv;
  logic [0:127]      o_instance_size;
  logic              o_new_instance;
  logic              o_pt_instance;
  logic              o_last;

  int tests = 0;
  int fails = 0;

  gcm_input_sequencer #(.CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_desc_valid         (i_desc_valid),
    .o_desc_ready         (o_desc_ready),
    .i_desc_key           (i_desc_key),
    .i_desc_iv            (i_desc_iv),
    .i_desc_aad_blocks    (i_desc_aad_blocks),
    .i_desc_pt_blocks     (i_desc_pt_blocks),
    .i_desc_instance_size (i_desc_instance_size),
    .i_data_valid         (i_data_valid),
    .o_data_ready         (o_data_ready),
    .i_data               (i_data),
    .o_valid              (o_valid),
    .o_cipher_key         (o_cipher_key),
    .o_plain_text         (o_plain_text),
    .o_aad                (o_aad),
    .o_iv                 (o_iv),
    .o_instance_size      (o_instance_size),
    .o_new_instance       (o_new_instance),
    .o_pt_instance        (o_pt_instance),
    .o_last               (o_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [127:0] key, input logic [95:0] iv,
                          input int aad, input int pt, input logic [127:0] size);
    i_desc_key           = key;
    i_desc_iv            = iv;
    i_desc_aad_blocks    = CNT_W'(aad);
    i_desc_pt_blocks     = CNT_W'(pt);
    i_desc_instance_size = size;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b0000) begin
      fails++; $display("FAIL reset.flags got %b exp 0000", {o_valid, o_new_instance, o_pt_instance, o_last});
    end
    tests++;
    if (o_cipher_key !== '0 || o_iv !== '0 || o_instance_size !== '0 || o_aad !== '0 || o_plain_text !== '0) begin
      fails++; $display("FAIL reset.data key %h iv %h size %h aad %h pt %h exp all 0", o_cipher_key, o_iv, o_instance_size, o_aad, o_plain_text);
    end
    tests++;
    if ({o_desc_ready, o_data_ready} !== 2'b00) begin
      fails++; $display("FAIL reset.ready_in_rst got %b exp 00", {o_desc_ready, o_data_ready});
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    tests++;
    if ({o_desc_ready, o_data_ready} !== 2'b10) begin
      fails++; $display("FAIL reset.ready_after got %b exp 10", {o_desc_ready, o_data_ready});
    end
  endtask

  task automatic test_aad_pt();
    logic [127:0] dat [4];
    logic         dv  [4];
    logic         rdy [4];
    logic [3:0]   fl  [4];
    logic [127:0] ea  [4];
    logic [127:0] ep  [4];
    dat = '{A0, P0, P1, 128'h0};
    dv  = '{1'b1, 1'b1, 1'b1, 1'b0};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    fl  = '{4'b1100, 4'b1010, 4'b1011, 4'b0000};
    ea  = '{A0, 128'h0, 128'h0, 128'h0};
    ep  = '{128'h0, P0, P1, 128'h0};
    set_desc(K1, IV1, 1, 2, S1);
    i_desc_valid = 1'b1;
    tests++;
    if (o_desc_ready !== 1'b1) begin
      fails++; $display("FAIL aad_pt.desc_ready got %b exp 1", o_desc_ready);
    end
    tick();
    i_desc_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_data_valid = dv[c];
      i_data       = dat[c];
      tests++;
      if (o_data_ready !== rdy[c]) begin
        fails++; $display("FAIL aad_pt.data_ready[%0d] got %b exp %b", c, o_data_ready, rdy[c]);
      end
      if (c == 3) begin
        tests++;
        if (o_desc_ready !== 1'b0) begin
          fails++; $display("FAIL aad_pt.desc_ready_on_last got %b exp 0", o_desc_ready);
        end
      end
      tick();
      tests++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== fl[c]) begin
        fails++; $display("FAIL aad_pt.flags[%0d] got %b exp %b", c, {o_valid, o_new_instance, o_pt_instance, o_last}, fl[c]);
      end
      tests++;
      if (o_aad !== ea[c] || o_plain_text !== ep[c]) begin
        fails++; $display("FAIL aad_pt.data[%0d] aad %h pt %h exp aad %h pt %h", c, o_aad, o_plain_text, ea[c], ep[c]);
      end
      tests++;
      if (o_cipher_key !== K1 || o_iv !== IV1 || o_instance_size !== S1) begin
        fails++; $display("FAIL aad_pt.held[%0d] key %h iv %h size %h", c, o_cipher_key, o_iv, o_instance_size);
      end
    end
    tests++;
    if (o_desc_ready !== 1'b1) begin
      fails++; $display("FAIL aad_pt.desc_ready_after got %b exp 1", o_desc_ready);
    end
  endtask

  task automatic test_empty();
    logic [3:0] fl  [2];
    logic       drd [2];
    fl  = '{4'b1101, 4'b0000};
    drd = '{1'b0, 1'b1};
    set_desc(K3, IV1, 0, 0, S1);
    i_desc_valid = 1'b1;
    tick();
    i_desc_valid = 1'b0;
    i_data_valid = 1'b1;
    i_data       = JUNK;
    for (int c = 0; c < 2; c++) begin
      tests++;
      if (o_data_ready !== 1'b0) begin
        fails++; $display("FAIL empty.data_ready[%0d] got %b exp 0", c, o_data_ready);
      end
      tick();
      tests++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== fl[c]) begin
        fails++; $display("FAIL empty.flags[%0d] got %b exp %b", c, {o_valid, o_new_instance, o_pt_instance, o_last}, fl[c]);
      end
      tests++;
      if (o_aad !== '0 || o_plain_text !== '0) begin
        fails++; $display("FAIL empty.data[%0d] aad %h pt %h exp 0", c, o_aad, o_plain_text);
      end
      tests++;
      if (o_desc_ready !== drd[c]) begin
        fails++; $display("FAIL empty.desc_ready[%0d] got %b exp %b", c, o_desc_ready, drd[c]);
      end
    end
    tests++;
    if (o_cipher_key !== K3) begin
      fails++; $display("FAIL empty.key got %h exp %h", o_cipher_key, K3);
    end
    i_data_valid = 1'b0;
  endtask

  task automatic test_gap();
    logic [127:0] dat [5];
    logic         dv  [5];
    logic         rdy [5];
    logic [3:0]   fl  [5];
    logic [127:0] ep  [5];
    dat = '{P0, JUNK, P1, P2, 128'h0};
    dv  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    fl  = '{4'b1110, 4'b0000, 4'b1010, 4'b1011, 4'b0000};
    ep  = '{P0, 128'h0, P1, P2, 128'h0};
    set_desc(K2, IV1, 0, 3, S1);
    i_desc_valid = 1'b1;
    tick();
    i_desc_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_data_valid = dv[c];
      i_data       = dat[c];
      tests++;
      if (o_data_ready !== rdy[c]) begin
        fails++; $display("FAIL gap.data_ready[%0d] got %b exp %b", c, o_data_ready, rdy[c]);
      end
      tick();
      tests++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== fl[c]) begin
        fails++; $display("FAIL gap.flags[%0d] got %b exp %b", c, {o_valid, o_new_instance, o_pt_instance, o_last}, fl[c]);
      end
      tests++;
      if (o_plain_text !== ep[c] || o_aad !== '0) begin
        fails++; $display("FAIL gap.data[%0d] pt %h aad %h exp pt %h aad 0", c, o_plain_text, o_aad, ep[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] dat [4];
    logic         dv  [4];
    logic         drd [4];
    logic [3:0]   fl  [4];
    logic [127:0] ek  [4];
    logic [95:0]  ei  [4];
    dat = '{P0, P1, 128'h0, 128'h0};
    dv  = '{1'b1, 1'b1, 1'b0, 1'b0};
    drd = '{1'b0, 1'b0, 1'b0, 1'b1};
    fl  = '{4'b1110, 4'b1011, 4'b0000, 4'b0000};
    ek  = '{K4, K4, K4, K5};
    ei  = '{IV4, IV4, IV4, IV5};
    set_desc(K4, IV4, 0, 2, S4);
    i_desc_valid = 1'b1;
    tick();
    set_desc(K5, IV5, 1, 0, S5);
    for (int c = 0; c < 4; c++) begin
      i_data_valid = dv[c];
      i_data       = dat[c];
      tests++;
      if (o_desc_ready !== drd[c]) begin
        fails++; $display("FAIL b2b.desc_ready[%0d] got %b exp %b", c, o_desc_ready, drd[c]);
      end
      tick();
      tests++;
      if ({o_valid, o_new_instance, o_pt_instance, o_last} !== fl[c]) begin
        fails++; $display("FAIL b2b.flags[%0d] got %b exp %b", c, {o_valid, o_new_instance, o_pt_instance, o_last}, fl[c]);
      end
      tests++;
      if (o_cipher_key !== ek[c] || o_iv !== ei[c]) begin
        fails++; $display("FAIL b2b.held[%0d] key %h iv %h exp key %h iv %h", c, o_cipher_key, o_iv, ek[c], ei[c]);
      end
    end
    i_desc_valid = 1'b0;
    i_data_valid = 1'b1;
    i_data       = A0;
    tests++;
    if (o_data_ready !== 1'b1) begin
      fails++; $display("FAIL b2b.aad_ready got %b exp 1", o_data_ready);
    end
    tick();
    i_data_valid = 1'b0;
    tests++;
    if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1101) begin
      fails++; $display("FAIL b2b.aad_only_flags got %b exp 1101", {o_valid, o_new_instance, o_pt_instance, o_last});
    end
    tests++;
    if (o_aad !== A0 || o_instance_size !== S5) begin
      fails++; $display("FAIL b2b.aad_only_data aad %h size %h exp %h %h", o_aad, o_instance_size, A0, S5);
    end
    tick();
    tests++;
    if ({o_valid, o_desc_ready, o_data_ready} !== 3'b010) begin
      fails++; $display("FAIL b2b.idle_after got %b exp 010", {o_valid, o_desc_ready, o_data_ready});
    end
  endtask

  task automatic test_reset_mid();
    set_desc(K6, IV4, 0, 4, S4);
    i_desc_valid = 1'b1;
    tick();
    i_desc_valid = 1'b0;
    i_data_valid = 1'b1;
    i_data       = P0;
    tick();
    tests++;
    if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1110 || o_plain_text !== P0) begin
      fails++; $display("FAIL rstmid.first_beat flags %b pt %h exp 1110 %h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_plain_text, P0);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b0000 || o_plain_text !== '0) begin
      fails++; $display("FAIL rstmid.outputs_cleared flags %b pt %h exp 0000 0", {o_valid, o_new_instance, o_pt_instance, o_last}, o_plain_text);
    end
    tests++;
    if (o_cipher_key !== '0 || {o_desc_ready, o_data_ready} !== 2'b00) begin
      fails++; $display("FAIL rstmid.key_ready key %h ready %b exp 0 00", o_cipher_key, {o_desc_ready, o_data_ready});
    end
    tick();
    rst = 1'b0;
    i_data_valid = 1'b0;
    #1;
    tests++;
    if ({o_desc_ready, o_data_ready, o_valid} !== 3'b100) begin
      fails++; $display("FAIL rstmid.idle_after got %b exp 100", {o_desc_ready, o_data_ready, o_valid});
    end
    set_desc(K7, IV5, 0, 1, S5);
    i_desc_valid = 1'b1;
    tick();
    i_desc_valid = 1'b0;
    i_data_valid = 1'b1;
    i_data       = P2;
    tick();
    i_data_valid = 1'b0;
    tests++;
    if ({o_valid, o_new_instance, o_pt_instance, o_last} !== 4'b1111 || o_plain_text !== P2) begin
      fails++; $display("FAIL rstmid.restart flags %b pt %h exp 1111 %h", {o_valid, o_new_instance, o_pt_instance, o_last}, o_plain_text, P2);
    end
    tests++;
    if (o_cipher_key !== K7 || o_iv !== IV5) begin
      fails++; $display("FAIL rstmid.restart_key key %h iv %h exp %h %h", o_cipher_key, o_iv, K7, IV5);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_aad_pt();
    test_empty();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
